// File: rtl/temperature_pkg.sv
// Shared types and constants for the temperature conversion table builder.
package temperature_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DIVIDE = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Conversion arithmetic: F = (9C+2)/5 + 32, C = (5(F-32)+4)/9
    localparam int F_OFFSET = 32;
    localparam int C2F_MUL  = 9;
    localparam int C2F_DIV  = 5;
    localparam int C2F_BIAS = 2;
    localparam int F2C_MUL  = 5;
    localparam int F2C_DIV  = 9;
    localparam int F2C_BIAS = 4;

    // Divider geometry: one quotient bit per numerator bit
    localparam int NUM_W      = 12;
    localparam int DEN_W      = 4;
    localparam int CNT_W      = 4;
    localparam int DIV_CYCLES = 12;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// done_o is high during the cycle whose closing edge produces the last
// quotient bit, so the caller can move on at that same edge.
module seq_divider
    import temperature_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NUM_W-1:0] numer_i,
    input  logic [DEN_W-1:0] denom_i,
    output logic [NUM_W-1:0] quot_o,
    output logic             done_o
);

    logic [DEN_W-1:0] r_rem;
    logic [NUM_W-1:0] r_quot;
    logic [DEN_W-1:0] r_den;
    logic [CNT_W-1:0] r_cnt;

    logic [DEN_W:0]   w_shift;
    logic             w_ge;
    logic [DEN_W-1:0] w_diff;

    // Remainder stays below the divisor, so the low bits of the difference suffice
    assign w_shift = {r_rem, r_quot[NUM_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});
    assign w_diff  = w_shift[DEN_W-1:0] - r_den;
    assign quot_o  = r_quot;
    assign done_o  = (r_cnt == CNT_W'(1));

    // Load operands on start, then shift-subtract until the count runs out
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rem  <= '0;
            r_quot <= '0;
            r_den  <= '0;
            r_cnt  <= '0;
        end else if (start_i) begin
            r_rem  <= '0;
            r_quot <= numer_i;
            r_den  <= denom_i;
            r_cnt  <= CNT_W'(DIV_CYCLES);
        end else if (r_cnt != '0) begin
            r_rem  <= w_ge ? w_diff : w_shift[DEN_W-1:0];
            r_quot <= {r_quot[NUM_W-2:0], w_ge};
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/temperature_table_builder.sv
// Builds the {unit, temperature} -> converted temperature table in RAM at
// run time, then serves registered lookups from it.
//
// state  | meaning
// LOAD   | form numerator/divisor for r_addr, start divider
// DIVIDE | divider running, 12 cycles
// WRITE  | offset + saturate/clamp, write RAM, advance address
// DONE   | table complete; rebuild_i restarts from address 0
module temperature_table_builder
    import temperature_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rebuild_i,
    input  logic [DATA_WIDTH-1:0] temperature_i,
    input  logic                  unit_i,
    output logic [DATA_WIDTH-1:0] temperature_o,
    output logic                  ready_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_temp;
    logic [DATA_WIDTH-1:0] r_ram [DEPTH];

    logic                  w_unit;
    logic [DATA_WIDTH-1:0] w_temp;
    logic [NUM_W-1:0]      w_temp_ext;
    logic                  w_f_below;
    logic [NUM_W-1:0]      w_numer;
    logic [DEN_W-1:0]      w_denom;
    logic [NUM_W-1:0]      w_quot;
    logic                  w_div_done;
    logic [NUM_W:0]        w_c2f_sum;
    logic [DATA_WIDTH-1:0] w_c2f_val;
    logic [DATA_WIDTH-1:0] w_f2c_val;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_unit     = r_addr[ADDR_WIDTH-1];
    assign w_temp     = r_addr[DATA_WIDTH-1:0];
    assign w_temp_ext = NUM_W'(w_temp);
    assign w_f_below  = (w_temp < DATA_WIDTH'(F_OFFSET));

    // Below-freezing Fahrenheit entries are clamped in WRITE; the divide is don't-care
    assign w_numer = w_unit
        ? (w_f_below ? '0
                     : NUM_W'(F2C_MUL) * (w_temp_ext - NUM_W'(F_OFFSET)) + NUM_W'(F2C_BIAS))
        : NUM_W'(C2F_MUL) * w_temp_ext + NUM_W'(C2F_BIAS);
    assign w_denom = w_unit ? DEN_W'(F2C_DIV) : DEN_W'(C2F_DIV);

    assign w_c2f_sum = {1'b0, w_quot} + (NUM_W + 1)'(F_OFFSET);
    assign w_c2f_val = (|w_c2f_sum[NUM_W:DATA_WIDTH]) ? '1 : w_c2f_sum[DATA_WIDTH-1:0];
    assign w_f2c_val = w_f_below ? '0
                     : ((|w_quot[NUM_W-1:DATA_WIDTH]) ? '1 : w_quot[DATA_WIDTH-1:0]);
    assign w_wdata   = w_unit ? w_f2c_val : w_c2f_val;

    seq_divider u_div (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (r_state == LOAD),
        .numer_i (w_numer),
        .denom_i (w_denom),
        .quot_o  (w_quot),
        .done_o  (w_div_done)
    );

    // Build sequencer: one table entry per LOAD/DIVIDE/WRITE pass
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= LOAD;
            r_addr  <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                LOAD:   r_state <= DIVIDE;
                DIVIDE: if (w_div_done) r_state <= WRITE;
                WRITE: begin
                    r_addr <= r_addr + ADDR_WIDTH'(1);
                    if (r_addr == '1) begin
                        r_state <= DONE;
                        r_ready <= 1'b1;
                    end else begin
                        r_state <= LOAD;
                    end
                end
                DONE: begin
                    if (rebuild_i) begin
                        r_state <= LOAD;
                        r_addr  <= '0;
                        r_ready <= 1'b0;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end

    // Table storage write port; contents need no reset since a build overwrites all
    always_ff @(posedge clk_i) begin
        if (r_state == WRITE) r_ram[r_addr] <= w_wdata;
    end

    // Registered lookup, forced to zero while the table is not ready or a rebuild starts
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          r_temp <= '0;
        else if (r_state == DONE && rebuild_i) r_temp <= '0;
        else if (r_ready)                   r_temp <= r_ram[{unit_i, temperature_i}];
        else                                r_temp <= '0;
    end

    assign temperature_o = r_temp;
    assign ready_o       = r_ready;

endmodule
